// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the shared memory port.
// master = arbiter side, slave = requester/memory environment side.
interface mem_bus_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;

  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        data_valid;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        mem_valid;

  logic        resp_orphan;

  modport master (
    input  instr_req, instr_addr,
    input  data_req, data_addr, data_we, data_be, data_wdata,
    input  mem_gnt, mem_rdata, mem_err, mem_valid,
    output instr_gnt, instr_rdata, instr_err, instr_valid,
    output data_gnt, data_rdata, data_err, data_valid,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output resp_orphan
  );

  modport slave (
    output instr_req, instr_addr,
    output data_req, data_addr, data_we, data_be, data_wdata,
    output mem_gnt, mem_rdata, mem_err, mem_valid,
    input  instr_gnt, instr_rdata, instr_err, instr_valid,
    input  data_gnt, data_rdata, data_err, data_valid,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  resp_orphan
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one pipelined memory port with in-order responses.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (data first).
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_bus_arbiter_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic [1:0] {ST_FREE, ST_LOCK_INSTR, ST_LOCK_DATA} lock_state_e;

  lock_state_e state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  owner_e owner_fifo_reg [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] slot_we;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_reg;
`endif

  owner_e sel, head;
  logic any_req, room, req_out, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A lock only holds while its owner keeps requesting; a dropped request frees the port.
  always_comb begin
    sel = OWN_INSTR;
    if (state_reg == ST_LOCK_INSTR && bus.instr_req) begin
      sel = OWN_INSTR;
    end else if (state_reg == ST_LOCK_DATA && bus.data_req) begin
      sel = OWN_DATA;
    end else if (bus.instr_req && bus.data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      sel = (last_owner_reg == OWN_DATA) ? OWN_INSTR : OWN_DATA;
`else
      sel = OWN_DATA;
`endif
    end else if (bus.data_req) begin
      sel = OWN_DATA;
    end
  end

  always_comb begin
    state_next = ST_FREE;
    if (req_out && !bus.mem_gnt) begin
      state_next = (sel == OWN_DATA) ? ST_LOCK_DATA : ST_LOCK_INSTR;
    end
  end

  // A full FIFO still accepts a request when a response retires in the same cycle.
  assign any_req = bus.instr_req | bus.data_req;
  assign room    = (count_reg < MAX_CNT) | ((count_reg == MAX_CNT) & bus.mem_valid);
  assign req_out = reset_n & any_req & room;
  assign push    = req_out & bus.mem_gnt;
  assign pop     = reset_n & bus.mem_valid & (count_reg != '0);
  assign head    = owner_fifo_reg[rd_ptr_reg];

  assign bus.mem_req   = req_out;
  assign bus.mem_addr  = (sel == OWN_DATA) ? bus.data_addr  : bus.instr_addr;
  assign bus.mem_we    = (sel == OWN_DATA) ? bus.data_we    : 1'b0;
  assign bus.mem_be    = (sel == OWN_DATA) ? bus.data_be    : 4'hF;
  assign bus.mem_wdata = (sel == OWN_DATA) ? bus.data_wdata : 32'h0;

  assign bus.instr_gnt = push & (sel == OWN_INSTR);
  assign bus.data_gnt  = push & (sel == OWN_DATA);

  assign bus.instr_valid = pop & (head == OWN_INSTR);
  assign bus.data_valid  = pop & (head == OWN_DATA);
  assign bus.instr_rdata = bus.instr_valid ? bus.mem_rdata : 32'h0;
  assign bus.instr_err   = bus.instr_valid & bus.mem_err;
  assign bus.data_rdata  = bus.data_valid ? bus.mem_rdata : 32'h0;
  assign bus.data_err    = bus.data_valid & bus.mem_err;
  assign bus.resp_orphan = reset_n & bus.mem_valid & (count_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_FREE;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_reg <= OWN_DATA;
`endif
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (push) last_owner_reg <= sel;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot_we
      assign slot_we[gi] = push & (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Owner storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (slot_we[i]) owner_fifo_reg[i] <= sel;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table-driven bench for mem_bus_arbiter (MAX_OUTSTANDING = 2) plus multi-cycle sequences.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef logic [108:0] out_t;

  typedef struct {
    string       name;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        dwe;
    logic        gnt;
    logic        mvalid;
    logic [31:0] mrdata;
    logic        merr;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];

  function automatic out_t exp_f(logic mreq, logic [31:0] maddr, logic mwe, logic [3:0] mbe,
                                 logic ig, logic dg, logic iv, logic dv,
                                 logic [31:0] ird, logic [31:0] drd, logic ie, logic de, logic orph);
    return {mreq, maddr, mwe, mbe, ig, dg, iv, dv, ird, drd, ie, de, orph};
  endfunction

  function automatic out_t act_f();
    return {bus_if.mem_req, bus_if.mem_addr, bus_if.mem_we, bus_if.mem_be,
            bus_if.instr_gnt, bus_if.data_gnt, bus_if.instr_valid, bus_if.data_valid,
            bus_if.instr_rdata, bus_if.data_rdata, bus_if.instr_err, bus_if.data_err,
            bus_if.resp_orphan};
  endfunction

  function automatic out_t hs_f();
    return {103'b0, bus_if.mem_req, bus_if.instr_gnt, bus_if.data_gnt,
            bus_if.instr_valid, bus_if.data_valid, bus_if.resp_orphan};
  endfunction

  function automatic vec_t mk(string name, logic ireq, logic [31:0] iaddr, logic dreq,
                              logic [31:0] daddr, logic dwe, logic gnt, logic mvalid,
                              logic [31:0] mrdata, logic merr, out_t e);
    vec_t v;
    v.name = name; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.dwe = dwe; v.gnt = gnt; v.mvalid = mvalid; v.mrdata = mrdata; v.merr = merr;
    v.exp = e;
    return v;
  endfunction

  task automatic apply(logic ireq, logic [31:0] iaddr, logic dreq, logic [31:0] daddr,
                       logic dwe, logic gnt, logic mvalid, logic [31:0] mrdata, logic merr);
    bus_if.instr_req  = ireq;
    bus_if.instr_addr = iaddr;
    bus_if.data_req   = dreq;
    bus_if.data_addr  = daddr;
    bus_if.data_we    = dwe;
    bus_if.mem_gnt    = gnt;
    bus_if.mem_valid  = mvalid;
    bus_if.mem_rdata  = mrdata;
    bus_if.mem_err    = merr;
  endtask

  task automatic check(string name, out_t act, out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  out_t seq_exp[3];

  initial begin
    bus_if.data_be    = 4'h3;
    bus_if.data_wdata = 32'h5555_5555;
    reset_n = 1'b0;
    apply(1, 32'h600, 1, 32'h700, 1, 1, 1, 32'h1234, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", hs_f(), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // mk(name, ireq, iaddr, dreq, daddr, dwe, gnt, mvalid, mrdata, merr, expected)
    vecs.push_back(mk("idle",        0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0, 0,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("lock_i1",     1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0, 0,
                      exp_f(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("lock_i2",     1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0, 0,
                      exp_f(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("lock_i3",     1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0, 0,
                      exp_f(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("lock_hold",   1, 32'h100, 1, 32'h200, 1, 0, 0, 32'h0, 0,
                      exp_f(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("grant_i",     1, 32'h100, 1, 32'h200, 1, 1, 0, 32'h0, 0,
                      exp_f(1, 32'h100, 0, 4'hF, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("grant_d",     0, 32'h0,   1, 32'h200, 1, 1, 0, 32'h0, 0,
                      exp_f(1, 32'h200, 1, 4'h3, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("full_block",  1, 32'h300, 0, 32'h0,   0, 1, 0, 32'h0, 0,
                      exp_f(0, 32'h300, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("full_pass",   1, 32'h300, 0, 32'h0,   0, 1, 1, 32'hAAAA_0001, 0,
                      exp_f(1, 32'h300, 0, 4'hF, 1, 0, 1, 0, 32'hAAAA_0001, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("rsp_data",    0, 32'h0,   0, 32'h0,   0, 0, 1, 32'hBBBB_0002, 1,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 0, 1, 32'h0, 32'hBBBB_0002, 0, 1, 0)));
    vecs.push_back(mk("rsp_wrap",    0, 32'h0,   0, 32'h0,   0, 0, 1, 32'hCCCC_0003, 1,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 1, 0, 32'hCCCC_0003, 32'h0, 1, 0, 0)));
    vecs.push_back(mk("orphan",      0, 32'h0,   0, 32'h0,   0, 0, 1, 32'hDEAD_0004, 1,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1)));
    vecs.push_back(mk("orphan_end",  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0, 0,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("drop_lock",   0, 32'h0,   1, 32'h400, 0, 0, 0, 32'h0, 0,
                      exp_f(1, 32'h400, 0, 4'h3, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("drop_switch", 1, 32'h500, 0, 32'h400, 0, 1, 0, 32'h0, 0,
                      exp_f(1, 32'h500, 0, 4'hF, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("rsp_drop",    0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h1111_2222, 0,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 1, 0, 32'h1111_2222, 32'h0, 0, 0, 0)));
    vecs.push_back(mk("orphan2",     0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h0000_0001, 0,
                      exp_f(0, 32'h0,   0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1)));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].daddr, vecs[i].dwe,
            vecs[i].gnt, vecs[i].mvalid, vecs[i].mrdata, vecs[i].merr);
      @(negedge clk);
      check(vecs[i].name, act_f(), vecs[i].exp);
    end

    // Both requesting with mem_gnt held: arbitration policy over three grants.
    @(posedge clk); #1;
    reset_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_again", hs_f(), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp[0] = exp_f(1, 32'h600, 0, 4'hF, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    seq_exp[1] = exp_f(1, 32'h700, 1, 4'h3, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    seq_exp[2] = exp_f(1, 32'h600, 0, 4'hF, 1, 0, 1, 0, 32'h2727_0001, 32'h0, 0, 0, 0);
`else
    seq_exp[0] = exp_f(1, 32'h700, 1, 4'h3, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    seq_exp[1] = exp_f(1, 32'h700, 1, 4'h3, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    seq_exp[2] = exp_f(1, 32'h700, 1, 4'h3, 0, 1, 0, 1, 32'h0, 32'h2727_0001, 0, 0, 0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      apply(1, 32'h600, 1, 32'h700, 1, 1, (c == 2), 32'h2727_0001, 0);
      @(negedge clk);
      check($sformatf("both_req_%0d", c), act_f(), seq_exp[c]);
    end

    // Second grant was data in either policy.
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 0, 0, 1, 32'h2727_0002, 0);
    @(negedge clk);
    check("drain_one", act_f(), exp_f(0, 32'h0, 0, 4'hF, 0, 0, 0, 1, 32'h0, 32'h2727_0002, 0, 0, 0));

    // Reset pulse between clock edges with one transaction still outstanding.
    @(posedge clk); #1;
    reset_n = 1'b0;
    apply(1, 32'h600, 1, 32'h700, 1, 1, 1, 32'h99, 0);
    #1;
    check("rst_async_hold", hs_f(), '0);
    #1;
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 1, 32'h3232_0001, 0);
    @(negedge clk);
    check("late_orphan", act_f(), exp_f(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1));
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 0, 0, 1, 32'h3232_0002, 0);
    @(negedge clk);
    check("late_orphan2", act_f(), exp_f(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1));
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    check("final_idle", act_f(), exp_f(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
